// File: rtl/uart_tx_engine.sv
// rtl/uart_tx_engine.sv - UART transmit engine: 11-bit-time frames with optional parity and 7/8 data bits
module uart_tx_engine (
    input  logic       clk,
    input  logic       rst,
    input  logic       btu,
    input  logic       load,
    input  logic [7:0] data,
    input  logic       eight,
    input  logic       pen,
    input  logic       ohel,
    output logic       tx,
    output logic       tx_rdy,
    output logic       doit
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_SEND = 2'd2
    } state_t;

    // Final bit count: the btu that would take the counter to 11 ends the frame
    localparam logic [3:0] LAST_BIT = 4'd10;

    state_t      state_q, state_d;
    logic [7:0]  data_q, data_d;
    logic        eight_q, eight_d;
    logic        pen_q, pen_d;
    logic        ohel_q, ohel_d;
    logic [10:0] shift_q, shift_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        parity;
    logic        par_slot;
    logic [10:0] frame;

    // Assemble the frame from the latched character and configuration
    always_comb begin
        parity   = (eight_q ? (^data_q) : (^data_q[6:0])) ^ ohel_q;
        par_slot = pen_q ? parity : 1'b1;
        if (eight_q) begin
            frame = {1'b1, par_slot, data_q, 1'b0};
        end else begin
            frame = {2'b11, par_slot, data_q[6:0], 1'b0};
        end
    end

    // State, latched configuration, shift register and bit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            data_q  <= 8'h00;
            eight_q <= 1'b0;
            pen_q   <= 1'b0;
            ohel_q  <= 1'b0;
            shift_q <= '1;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            eight_q <= eight_d;
            pen_q   <= pen_d;
            ohel_q  <= ohel_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic and state-decoded outputs; tx comes straight from a flop
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        eight_d = eight_q;
        pen_d   = pen_q;
        ohel_d  = ohel_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        tx_rdy  = 1'b0;
        doit    = 1'b0;
        tx      = shift_q[0];

        case (state_q)
            S_IDLE: begin
                tx_rdy = 1'b1;
                // btu is meaningless here; only a load starts anything
                if (load) begin
                    data_d  = data;
                    eight_d = eight;
                    pen_d   = pen;
                    ohel_d  = ohel;
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                // One cycle to let the latched config settle into the frame image
                shift_d = frame;
                cnt_d   = 4'd0;
                state_d = S_SEND;
            end
            S_SEND: begin
                doit = 1'b1;
                if (btu) begin
                    if (cnt_q == LAST_BIT) begin
                        shift_d = '1;
                        cnt_d   = 4'd0;
                        state_d = S_IDLE;
                    end else begin
                        shift_d = {1'b1, shift_q[10:1]};
                        cnt_d   = cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                shift_d = '1;
                cnt_d   = 4'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb/tb_uart_tx_engine.sv - directed self-checking bench for uart_tx_engine
module tb_uart_tx_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic       btu;
    logic       load;
    logic [7:0] data;
    logic       eight;
    logic       pen;
    logic       ohel;
    logic       tx;
    logic       tx_rdy;
    logic       doit;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_engine dut (
        .clk    (clk),
        .rst    (rst),
        .btu    (btu),
        .load   (load),
        .data   (data),
        .eight  (eight),
        .pen    (pen),
        .ohel   (ohel),
        .tx     (tx),
        .tx_rdy (tx_rdy),
        .doit   (doit)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Compare the three outputs against expected values
    task automatic chk_out(input string name, input logic etx, input logic erdy, input logic edoit);
        n_checks++;
        if (tx !== etx || tx_rdy !== erdy || doit !== edoit) begin
            n_fail++;
            $display("FAIL %s: tx/tx_rdy/doit got %b%b%b want %b%b%b", name, tx, tx_rdy, doit, etx, erdy, edoit);
        end
    endtask

    // Present load for one cycle, then scramble inputs to prove they were latched
    task automatic start_frame(input string name, input logic [7:0] d, input logic e, input logic p,
                               input logic o, input logic btu_in_arm);
        data = d; eight = e; pen = p; ohel = o; load = 1'b1;
        tick;
        load = 1'b0; data = ~d; eight = ~e; pen = ~p; ohel = ~o;
        chk_out({name, " arm"}, 1'b1, 1'b0, 1'b0);
        btu = btu_in_arm;
        tick;
        btu = 1'b0;
        chk_out({name, " start"}, 1'b0, 1'b0, 1'b1);
    endtask

    // Pulse btu nbtu times, 16 clocks per bit, recording the line before each pulse
    task automatic run_bits(input string name, input int nbtu, input logic inject, output logic [10:0] obs);
        obs = '1;
        for (int k = 0; k < nbtu; k++) begin
            for (int i = 0; i < 15; i++) begin
                if (inject && k == 3 && i == 5) begin
                    load = 1'b1;
                    data = 8'h00;
                end else begin
                    load = 1'b0;
                end
                tick;
            end
            load = 1'b0;
            obs[k] = tx;
            if (k == 10) chk_out({name, " last bit"}, tx, 1'b0, 1'b1);
            btu = 1'b1;
            tick;
            btu = 1'b0;
        end
    endtask

    task automatic do_frame(input string name, input logic [7:0] d, input logic e, input logic p,
                            input logic o, input logic [10:0] exp, input logic arm_btu, input logic inject);
        logic [10:0] obs;
        start_frame(name, d, e, p, o, arm_btu);
        run_bits(name, 11, inject, obs);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s bits: got %b want %b (bit0 rightmost)", name, obs, exp);
        end
        chk_out({name, " end"}, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) tick;
    endtask

    task automatic test_reset;
        rst = 1'b1; load = 1'b0; btu = 1'b0; data = 8'h00; eight = 1'b1; pen = 1'b0; ohel = 1'b0;
        idle(2);
        rst = 1'b0;
        chk_out("reset", 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            btu = 1'b1; tick; btu = 1'b0; idle(3);
        end
        chk_out("reset btu idle", 1'b1, 1'b1, 1'b0);
        rst = 1'b1; load = 1'b1; btu = 1'b1;
        tick;
        rst = 1'b0; load = 1'b0; btu = 1'b0;
        chk_out("reset over load", 1'b1, 1'b1, 1'b0);
        tick;
        chk_out("reset over load next", 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_frame_8bit;
        do_frame("h55 8e", 8'h55, 1'b1, 1'b1, 1'b0, 11'b10010101010, 1'b0, 1'b0);
        idle(4);
    endtask

    task automatic test_frame_7bit;
        do_frame("h41 7n", 8'h41, 1'b0, 1'b0, 1'b0, 11'b11110000010, 1'b0, 1'b0);
        idle(3);
        do_frame("h41 7o", 8'h41, 1'b0, 1'b1, 1'b1, 11'b11110000010, 1'b1, 1'b0);
        idle(3);
        do_frame("h41 7e", 8'h41, 1'b0, 1'b1, 1'b0, 11'b11010000010, 1'b0, 1'b0);
        idle(3);
    endtask

    task automatic test_load_ignored;
        do_frame("hFF 8o", 8'hFF, 1'b1, 1'b1, 1'b1, 11'b11111111110, 1'b0, 1'b1);
        idle(5);
        chk_out("after ignored load", 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_reset_midframe;
        logic [10:0] obs;
        start_frame("hA5 rst", 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
        run_bits("hA5 rst", 5, 1'b0, obs);
        n_checks++;
        if (obs[4:0] !== 5'b01010) begin
            n_fail++;
            $display("FAIL hA5 partial bits: got %b want %b", obs[4:0], 5'b01010);
        end
        chk_out("hA5 bit5", 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk_out("midframe reset", 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            idle(5); btu = 1'b1; tick; btu = 1'b0;
            chk_out("post reset btu", 1'b1, 1'b1, 1'b0);
        end
    endtask

    task automatic test_back_to_back;
        do_frame("b2b first", 8'h55, 1'b1, 1'b1, 1'b0, 11'b10010101010, 1'b0, 1'b0);
        do_frame("b2b second", 8'h41, 1'b0, 1'b0, 1'b0, 11'b11110000010, 1'b0, 1'b0);
        idle(2);
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; btu = 1'b0; data = 8'h00; eight = 1'b0; pen = 1'b0; ohel = 1'b0;
        test_reset;
        test_frame_8bit;
        test_frame_7bit;
        test_load_ignored;
        test_reset_midframe;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_engine.md
UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 Port clk, input, 1, system clock; all state updates on rising edge.
REQ-002 Port rst, input, 1, synchronous active-high reset, sampled on clk rising edge.
REQ-003 Port btu, input, 1, one-cycle bit-time-up pulse from the bit time counter.
REQ-004 Port load, input, 1, request to transmit data; accepted only when tx_rdy=1.
REQ-005 Port data, input, 8, character to send, LSB first.
REQ-006 Port eight, input, 1, 1 = 8 data bits, 0 = 7 data bits (data[6:0]).
REQ-007 Port pen, input, 1, 1 = parity bit enabled.
REQ-008 Port ohel, input, 1, parity sense: 0 = even, 1 = odd.
REQ-009 Port tx, output, 1, serial line; idle/mark = 1.
REQ-010 Port tx_rdy, output, 1, 1 = idle and able to accept load.
REQ-011 Port doit, output, 1, enable for the bit time counter; high for the whole frame.

Function
REQ-012 Every frame SHALL be exactly 11 bit times: start(0), data LSB first, optional parity, then 1s to fill.
REQ-013 Frame bit order with eight=1: start, d0..d7, P-or-1, 1.
REQ-014 Frame bit order with eight=0: start, d0..d6, P-or-1, 1, 1.
REQ-015 P = XOR of the transmitted data bits (7 or 8) when ohel=0, its inverse when ohel=1; slot carries 1 when pen=0.
REQ-016 eight, pen, ohel and data SHALL be captured in the cycle load is accepted; later changes do not affect the frame in progress.
REQ-017 States: IDLE (tx_rdy=1, doit=0), ARM (one cycle), SEND (doit=1).
REQ-018 IDLE->ARM: load=1 at edge N; tx_rdy=0 from N+1; data/config latched.
REQ-019 ARM->SEND: at edge N+2, 11-bit shift register loaded with frame, bit counter cleared, doit=1.
REQ-020 tx SHALL equal shift register bit 0 (a flop output, no combinational logic); start bit appears on tx from N+2.
REQ-021 In SEND, each btu=1 SHALL shift the register right with 1 fill and increment the 4-bit bit counter.
REQ-022 On the btu that takes the bit counter from 10 to 11: doit=0, tx_rdy=1, counter cleared, return to IDLE, tx=1.
REQ-023 load while tx_rdy=0 SHALL be ignored (no queuing, no frame corruption).
REQ-024 btu while doit=0 (IDLE or ARM) SHALL be ignored.
REQ-025 load accepted in the same cycle a frame ends is impossible by construction: tx_rdy rises the edge after the last btu; a load on that same edge is ignored.
REQ-026 Bit counter SHALL never exceed 11; no wrap-around to 0 mid-frame.
REQ-027 Next frame may begin with load in the first cycle tx_rdy=1; no extra idle time is required beyond the stop bits.

Reset
REQ-028 rst=1 at an edge SHALL force: tx=1, tx_rdy=1, doit=0, shift register all 1s, bit counter 0, state IDLE.
REQ-029 rst SHALL override load and btu in the same cycle.
REQ-030 rst mid-frame SHALL abort the frame; tx=1 at the following edge, no partial bits resume after rst deasserts.

Verification
REQ-031 After rst: tx=1, tx_rdy=1, doit=0; load=0, btu pulsing -> outputs unchanged.
REQ-032 data=8'h55, eight=1, pen=1, ohel=0, load one cycle, btu every 16 clk -> tx sequence 0,1,0,1,0,1,0,1,0,0,1; tx_rdy=1 after 11th btu.
REQ-033 data=8'h41, eight=0, pen=0 -> tx 0,1,0,0,0,0,0,1,1,1,1; same data with pen=1, ohel=1 -> parity slot 1 (two ones, odd sense).
REQ-034 data=8'hFF, eight=1, pen=1, ohel=1 -> tx 0,1,1,1,1,1,1,1,1,1,1; second load 8'h00 during frame ignored, line matches first frame only.
REQ-035 rst asserted after 5th btu of 8'hA5 frame -> tx=1, tx_rdy=1, doit=0 next edge; subsequent btu pulses cause no transitions.
REQ-036 Back-to-back: load asserted in first cycle tx_rdy=1 -> doit low for exactly 2 cycles between frames, start bit at the next ARM->SEND edge.
